fetch_cycle: RTL

Instruction-fetch stage of the pipelined RV32I core: owns the program counter, issues requests to instruction memory over a ready/valid interface, and drives the IF/ID pipeline register that feeds the decode stage (InstrD, PCD, PCPlus4D). It absorbs variable memory latency, decode stalls and flushes, and branch redirects from execute (PCSrcE/PCTargetE). At most one memory request is outstanding.

---
 rtl/fetch_cycle.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_cycle.sv
// rtl/fetch_cycle.sv - RV32I instruction-fetch stage: PC, imem request FSM, IF/ID register
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {FETCH, HELD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pcf, pcf_nxt;
  logic [31:0] buf_q, buf_nxt;
  logic [31:0] old_addr, old_addr_nxt;
  logic [31:0] instr_nxt, pcd_nxt, pcplus4_nxt;
  logic        valid_nxt;
  logic [31:0] pc_plus4, target_al, load_word;
  logic        hold, load;
  logic        unused_target_lsbs;

  assign unused_target_lsbs = ^PCTargetE[1:0];
  assign pc_plus4  = pcf + 32'd4;
  assign target_al = {PCTargetE[31:2], 2'b00};
  // A flush empties IF/ID anyway, so a stall alongside it must not park a word in the buffer
  assign hold      = StallD & ~FlushD;

  // Request depends only on registered state; DISCARD keeps presenting the abandoned address
  assign IMemReq  = rst & (state != HELD);
  assign IMemAddr = (state == DISCARD) ? old_addr : pcf;

  always_comb begin
    state_nxt    = state;
    pcf_nxt      = pcf;
    buf_nxt      = buf_q;
    old_addr_nxt = old_addr;
    load         = 1'b0;
    load_word    = IMemRData;
    instr_nxt    = InstrD;
    pcd_nxt      = PCD;
    pcplus4_nxt  = PCPlus4D;
    valid_nxt    = ValidD;

    case (state)
      FETCH: begin
        if (PCSrcE) begin
          pcf_nxt = target_al;
          if (!IMemReady) begin
            state_nxt    = DISCARD;
            old_addr_nxt = pcf;
          end
        end else if (IMemReady) begin
          if (hold) begin
            buf_nxt   = IMemRData;
            state_nxt = HELD;
          end else begin
            load    = 1'b1;
            pcf_nxt = pc_plus4;
          end
        end
      end
      HELD: begin
        if (PCSrcE) begin
          pcf_nxt   = target_al;
          state_nxt = FETCH;
        end else if (!hold) begin
          load      = 1'b1;
          load_word = buf_q;
          pcf_nxt   = pc_plus4;
          state_nxt = FETCH;
        end
      end
      DISCARD: begin
        if (PCSrcE) pcf_nxt = target_al;
        if (IMemReady) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    if (PCSrcE || FlushD) begin
      instr_nxt   = NOP_INSTR;
      pcd_nxt     = 32'h0;
      pcplus4_nxt = 32'h0;
      valid_nxt   = 1'b0;
    end else if (load) begin
      instr_nxt   = load_word;
      pcd_nxt     = pcf;
      pcplus4_nxt = pc_plus4;
      valid_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH;
      pcf      <= RESET_PC;
      buf_q    <= 32'h0;
      old_addr <= 32'h0;
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pcf      <= pcf_nxt;
      buf_q    <= buf_nxt;
      old_addr <= old_addr_nxt;
      InstrD   <= instr_nxt;
      PCD      <= pcd_nxt;
      PCPlus4D <= pcplus4_nxt;
      ValidD   <= valid_nxt;
    end
  end

endmodule
